// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port.
// A grant holds for up to BURST consecutive beats and stalls on wfull.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DW-1:0]           wdata,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [OW-1:0] cand;
    logic [OW-1:0] search_idx;
    logic          found;
    logic [OW-1:0] grant;
    logic          grant_vld;
    logic          open;
    logic          beat;

    // Rotating priority: the requester after the last owner is searched first.
    always_comb begin
        found      = 1'b0;
        search_idx = last_q;
        cand       = last_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = OW'((32'(last_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found      = 1'b1;
                search_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant     = last_q;
        grant_vld = 1'b0;

        if (state_q == HOLD) begin
            grant_vld = 1'b1;
        end else begin
            grant     = search_idx;
            grant_vld = found;
        end

        open = grant_vld & ~wfull & wrst_n;
        beat = open & req_valid[grant];

        case (state_q)
            IDLE: begin
                if (beat) begin
                    last_d = grant;
                    cnt_d  = CW'(1);
                    if (BURST > 1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A dropped valid ends the grant even while the FIFO is full.
                if (!req_valid[last_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat) begin
                    if (cnt_q + CW'(1) == CW'(BURST)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (OW'(i) == grant) begin
                req_ready[i] = open;
                wdata        = req_data[i*DW +: DW];
            end
        end
    end

    assign winc  = beat;
    assign owner = last_q;
    assign busy  = (state_q == HOLD);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: a grant/beats-left reference model queues
// per-cycle expectations, and a monitor compares them against the DUT mid-cycle.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int OW    = $clog2(NREQ);

    logic                wclk;
    logic                wrst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                wfull;
    logic                winc;
    logic [DW-1:0]       wdata;
    logic [OW-1:0]       owner;
    logic                busy;

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic            winc;
        logic [DW-1:0]   data;
        logic [NREQ-1:0] ready;
        logic [OW-1:0]   owner;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int model_beats = 0;
    int dut_beats = 0;

    // Reference model: current grant holder and how many beats it may still take.
    int            m_owner = NREQ - 1;
    int            m_left  = 0;
    logic [DW-1:0] pd [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic [NREQ-1:0] v, input logic f, input logic r);
        exp_t e;
        int   g;
        bit   have;
        bit   bt;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = pd[i];
        req_valid = v;
        wfull     = f;
        wrst_n    = r;

        e.winc  = 1'b0;
        e.data  = '0;
        e.ready = '0;
        e.owner = OW'(NREQ - 1);
        e.busy  = 1'b0;
        if (!r) begin
            m_owner = NREQ - 1;
            m_left  = 0;
        end else begin
            e.owner = OW'(m_owner);
            e.busy  = (m_left > 0);
            have = 1'b0;
            g    = m_owner;
            if (m_left > 0) begin
                have = 1'b1;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!have && v[(m_owner + k) % NREQ]) begin
                        have = 1'b1;
                        g    = (m_owner + k) % NREQ;
                    end
                end
            end
            if (have && !f) e.ready[g] = 1'b1;
            bt = have && !f && v[g];
            if (m_left > 0 && !v[g]) begin
                m_left = 0;
            end else if (bt) begin
                if (m_left > 0) begin
                    m_left--;
                end else begin
                    m_owner = g;
                    m_left  = BURST - 1;
                end
            end
            e.winc = bt;
            if (bt) begin
                e.data = pd[g];
                pd[g]  = pd[g] + 8'd1;
                model_beats++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation record per driven cycle, checked on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (winc === 1'b1) dut_beats++;
                chk("winc", 32'(winc), 32'(e.winc));
                if (e.winc) chk("wdata", 32'(wdata), 32'(e.data));
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                chk("owner", 32'(owner), 32'(e.owner));
                chk("busy", 32'(busy), 32'(e.busy));
                if (winc === 1'b1 && wfull === 1'b1) chk("winc_while_full", 32'(winc), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rv;
        wrst_n    = 1'b0;
        req_valid = '0;
        wfull     = 1'b0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) pd[i] = 8'(i * 8'h40);

        repeat (3) cyc('0, 1'b0, 1'b0);

        // All requesters continuously valid: four-beat bursts rotating 0,1,2,3,0.
        repeat (20) cyc({NREQ{1'b1}}, 1'b0, 1'b1);
        repeat (2) cyc('0, 1'b0, 1'b1);

        // Single requester 2 with a burst boundary in the middle.
        pd[2] = 8'hA0;
        repeat (6) cyc(4'b0100, 1'b0, 1'b1);
        repeat (2) cyc('0, 1'b0, 1'b1);

        // Requester 1 stalled by wfull mid-grant.
        repeat (2) cyc(4'b0010, 1'b0, 1'b1);
        repeat (3) cyc(4'b0010, 1'b1, 1'b1);
        repeat (3) cyc(4'b0010, 1'b0, 1'b1);
        repeat (2) cyc('0, 1'b0, 1'b1);

        // Requester 3 drops valid: one bubble, then requester 0 after wrap.
        cyc(4'b1000, 1'b0, 1'b1);
        cyc(4'b0001, 1'b0, 1'b1);
        cyc(4'b0001, 1'b0, 1'b1);
        repeat (2) cyc('0, 1'b0, 1'b1);

        // Reset pulsed mid-burst of requester 2.
        repeat (2) cyc(4'b0100, 1'b0, 1'b1);
        repeat (2) cyc({NREQ{1'b1}}, 1'b0, 1'b0);
        repeat (4) cyc({NREQ{1'b1}}, 1'b0, 1'b1);

        // Random traffic with frequent full stalls.
        repeat (10000) begin
            for (int i = 0; i < NREQ; i++) rv[i] = ($urandom_range(0, 3) != 0);
            cyc(rv, ($urandom_range(0, 3) == 0), 1'b1);
        end
        repeat (2) cyc('0, 1'b0, 1'b1);

        @(negedge wclk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("beat_total", 32'(dut_beats), 32'(model_beats));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
